// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch front end. Owns the program counter, issues word fetches
// to instruction memory over a req/ack handshake and presents a registered
// PC/instruction pair to the IF/ID pipeline register. A one-entry skid buffer
// catches a fetch that completes while the output is stalled. A redirect
// flushes the output and restarts fetching at the new target. An in-flight
// request is never abandoned: its response is waited for and thrown away.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   stall_i        downstream cannot accept; output is held
//   redirect_i     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  redirect target (bits [1:0] forced to zero)
//   imem_req_o     fetch request
//   imem_addr_o    fetch address, stable until acknowledged
//   imem_ack_i     memory completes the request this cycle
//   imem_rdata_i   instruction word, valid with imem_ack_i
//   PC_o           PC of instruction_o
//   instruction_o  fetched instruction
//   valid_o        PC_o/instruction_o hold a real instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PC_o,
    output logic [31:0] instruction_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] fetch_pc;
    logic [31:0] drop_addr;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic [31:0] redirect_target;
    logic        accept;

    // Output register can take a new value when it is empty or not stalled.
    assign accept          = !stall_i || !valid_o;
    assign redirect_target = redirect_pc_i & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus bus outputs. The bus outputs depend on registers only.
    always_comb begin
        state_n     = state;
        imem_req_o  = 1'b0;
        imem_addr_o = fetch_pc;

        case (state)
            REQ: begin
                imem_req_o = 1'b1;
            end
            DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = drop_addr;
            end
            default: begin
            end
        endcase

        if (redirect_i) begin
            // An unacknowledged request must stay on the bus, so the flush
            // parks in DROP until that response has been consumed.
            if ((state == REQ && !imem_ack_i) || state == DROP) begin
                state_n = DROP;
            end else begin
                state_n = REQ;
            end
        end else begin
            case (state)
                IDLE: state_n = REQ;
                REQ:  if (imem_ack_i && !accept) state_n = HOLD;
                HOLD: if (!stall_i) state_n = REQ;
                DROP: if (imem_ack_i) state_n = REQ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            drop_addr     <= '0;
            skid_pc       <= '0;
            skid_instr    <= '0;
            PC_o          <= '0;
            instruction_o <= '0;
            valid_o       <= 1'b0;
        end else if (redirect_i) begin
            PC_o          <= '0;
            instruction_o <= '0;
            valid_o       <= 1'b0;
            fetch_pc      <= redirect_target;
            // Remember the address still on the bus before fetch_pc moves.
            if (state == REQ && !imem_ack_i) begin
                drop_addr <= fetch_pc;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem_ack_i) begin
                        fetch_pc <= fetch_pc + PC_STEP;
                        if (accept) begin
                            PC_o          <= fetch_pc;
                            instruction_o <= imem_rdata_i;
                            valid_o       <= 1'b1;
                        end else begin
                            skid_pc    <= fetch_pc;
                            skid_instr <= imem_rdata_i;
                        end
                    end else if (accept) begin
                        valid_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        PC_o          <= skid_pc;
                        instruction_o <= skid_instr;
                        valid_o       <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed scenarios followed by a randomized run. A memory model with
// configurable latency answers fetches with a word derived from the address.
// The reference model tracks the instruction stream abstractly: outputs must
// be consecutive word addresses starting at reset or at the latest redirect
// target, held while stalled, zeroed on redirect. Requests must be held
// until acknowledged.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] PC_o;
    logic [31:0] instruction_o;
    logic        valid_o;

    int checks   = 0;
    int failures = 0;

    // memory model state
    int unsigned min_lat;
    int unsigned max_lat;
    int unsigned wait_cnt;
    bit          mem_busy;

    // reference model state
    bit          model_on;
    bit          drop_pending;
    logic [31:0] exp_out_pc;
    logic [31:0] exp_req_pc;
    int          emitted;

    if_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .PC_o         (PC_o),
        .instruction_o(instruction_o),
        .valid_o      (valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_out_pc   = 32'h0;
        exp_req_pc   = 32'h0;
        drop_pending = 1'b0;
    endtask

    // Decide the memory response for the coming edge from the settled bus.
    task automatic mem_drive();
        if (rst || !imem_req_o) begin
            imem_ack_i   = 1'b0;
            imem_rdata_i = $urandom;
            mem_busy     = 1'b0;
        end else begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                wait_cnt = $urandom_range(max_lat, min_lat);
            end
            if (wait_cnt == 0) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = word_at(imem_addr_o);
                mem_busy     = 1'b0;
            end else begin
                imem_ack_i   = 1'b0;
                imem_rdata_i = $urandom;
                wait_cnt--;
            end
        end
    endtask

    // One clock: snapshot pre-edge, advance, check against the model.
    task automatic cycle();
        logic        p_req, p_valid, p_stall, p_redir, p_ack, p_rst;
        logic [31:0] p_addr, p_pc, p_instr, p_tgt;
        p_req   = imem_req_o;
        p_addr  = imem_addr_o;
        p_valid = valid_o;
        p_pc    = PC_o;
        p_instr = instruction_o;
        p_stall = stall_i;
        p_redir = redirect_i;
        p_tgt   = redirect_pc_i;
        p_ack   = imem_ack_i;
        p_rst   = rst;
        @(posedge clk);
        #1;
        if (model_on && !p_rst && !rst) begin
            if (p_req && !p_ack) begin
                chk("hs_req_held", imem_req_o, 1);
                chk("hs_addr_held", imem_addr_o, p_addr);
            end
            if (p_redir) begin
                chk("redir_valid", valid_o, 0);
                chk("redir_pc", PC_o, 0);
                chk("redir_instr", instruction_o, 0);
                exp_out_pc   = p_tgt & ~32'h3;
                exp_req_pc   = p_tgt & ~32'h3;
                drop_pending = p_req && (drop_pending || !p_ack);
            end else begin
                if (p_req && p_ack) begin
                    if (drop_pending) begin
                        drop_pending = 1'b0;
                    end else begin
                        chk("req_addr", p_addr, exp_req_pc);
                        exp_req_pc += 32'd4;
                    end
                end
                if (p_valid && p_stall) begin
                    chk("stall_valid", valid_o, 1);
                    chk("stall_pc", PC_o, p_pc);
                    chk("stall_instr", instruction_o, p_instr);
                end else if (valid_o) begin
                    chk("out_pc", PC_o, exp_out_pc);
                    chk("out_instr", instruction_o, word_at(exp_out_pc));
                    exp_out_pc += 32'd4;
                    emitted++;
                end
            end
        end
        mem_drive();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = '0;
        mem_busy      = 1'b0;
        model_on      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        model_on = 1'b1;
        mem_drive();
    endtask

    initial begin
        emitted = 0;
        min_lat = 0;
        max_lat = 0;

        // Reset state
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        imem_ack_i = 1'b0;
        imem_rdata_i = '0;
        #3;
        chk("rst_valid", valid_o, 0);
        chk("rst_pc", PC_o, 0);
        chk("rst_instr", instruction_o, 0);
        chk("rst_req", imem_req_o, 0);

        // Zero-wait stream, then stall while the 0x10 response arrives
        do_reset();
        for (int unsigned i = 0; i < 5; i++) begin
            cycle();
            chk("t1_addr", imem_addr_o, 32'(i * 4));
            chk("t1_req", imem_req_o, 1);
            if (i == 0) chk("t1_first_valid", valid_o, 0);
            else        chk("t1_pc", PC_o, 32'((i - 1) * 4));
        end
        stall_i = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            cycle();
            chk("t2_hold_req", imem_req_o, 0);
            chk("t2_hold_pc", PC_o, 32'h0C);
        end
        stall_i = 1'b0;
        cycle();
        chk("t2_skid_pc", PC_o, 32'h10);
        chk("t2_skid_valid", valid_o, 1);
        chk("t2_next_addr", imem_addr_o, 32'h14);
        chk("t2_next_req", imem_req_o, 1);

        // Slow memory, redirect while the 0x08 request is pending
        min_lat = 2;
        max_lat = 2;
        do_reset();
        for (int k = 0; k < 40 && !(imem_req_o && imem_addr_o == 32'h08); k++) cycle();
        chk("t3_reach_08", imem_addr_o, 32'h08);
        cycle();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        cycle();
        redirect_i = 1'b0;
        chk("t3_drop_req", imem_req_o, 1);
        chk("t3_drop_addr", imem_addr_o, 32'h08);
        for (int k = 0; k < 10 && imem_addr_o == 32'h08; k++) begin
            chk("t3_drop_valid", valid_o, 0);
            cycle();
        end
        chk("t3_new_addr", imem_addr_o, 32'h200);
        for (int k = 0; k < 20 && !valid_o; k++) cycle();
        chk("t3_first_valid", valid_o, 1);
        chk("t3_first_pc", PC_o, 32'h200);

        // Redirect coinciding with the 0x40 response; then wrap-around
        min_lat = 0;
        max_lat = 0;
        do_reset();
        for (int k = 0; k < 40 && imem_addr_o != 32'h40; k++) cycle();
        chk("t4_reach_40", imem_addr_o, 32'h40);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h103;
        cycle();
        redirect_i = 1'b0;
        chk("t4_valid", valid_o, 0);
        chk("t4_addr", imem_addr_o, 32'h100);
        chk("t4_req", imem_req_o, 1);
        cycle();
        chk("t4_pc", PC_o, 32'h100);
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFA;
        cycle();
        redirect_i = 1'b0;
        cycle();
        chk("wrap_pc0", PC_o, 32'hFFFF_FFF8);
        cycle();
        chk("wrap_pc1", PC_o, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc2", PC_o, 32'h0);

        // Redirect while stalled with the skid full
        do_reset();
        repeat (4) cycle();
        stall_i = 1'b1;
        cycle();
        chk("t5_hold_req", imem_req_o, 0);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h300;
        cycle();
        redirect_i = 1'b0;
        chk("t5_valid", valid_o, 0);
        stall_i = 1'b0;
        for (int k = 0; k < 10 && !valid_o; k++) cycle();
        chk("t5_pc", PC_o, 32'h300);

        // Reset mid-request, late ack during IDLE
        do_reset();
        repeat (6) cycle();
        rst = 1'b1;
        model_on = 1'b0;
        mem_busy = 1'b0;
        #1;
        chk("t6_valid", valid_o, 0);
        chk("t6_pc", PC_o, 0);
        chk("t6_instr", instruction_o, 0);
        chk("t6_req", imem_req_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        model_on = 1'b1;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        cycle();
        chk("t6_idle_valid", valid_o, 0);
        chk("t6_req_after", imem_req_o, 1);
        chk("t6_addr_after", imem_addr_o, 32'h0);
        cycle();
        chk("t6_first_pc", PC_o, 32'h0);
        chk("t6_first_instr", instruction_o, word_at(32'h0));

        // Randomized run
        min_lat = 0;
        max_lat = 3;
        do_reset();
        emitted = 0;
        for (int n = 0; n < 2000; n++) begin
            stall_i    = ($urandom_range(9, 0) < 3);
            redirect_i = ($urandom_range(31, 0) == 0);
            if ($urandom_range(3, 0) == 0) redirect_pc_i = 32'hFFFF_FFF0 | $urandom_range(15, 0);
            else                           redirect_pc_i = $urandom;
            cycle();
        end
        stall_i = 1'b0;
        redirect_i = 1'b0;
        for (int k = 0; k < 30 && !valid_o; k++) cycle();
        chk("drain_valid", valid_o, 1);
        chk("rand_progress", 32'(emitted > 200), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage front end: owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and produces the PC/instruction stream consumed by the IF/ID pipeline register.
- Honors back-pressure (stall) from the hazard unit and control-flow redirects (branch/jump flush) from ID/EX.
- Contains a one-entry skid buffer, so a fetch that completes during a stall is never lost.

Parameters:
- RESET_PC, 32'h00000000, PC fetched first after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall_i  input  1  downstream cannot accept; output held.
- redirect_i  input  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  fetch address, stable while imem_req_o high and unacked.
- imem_ack_i  input  1  memory completes the request this cycle.
- imem_rdata_i  input  32  instruction word, valid when imem_ack_i=1.
- PC_o  output  32  PC of instruction_o.
- instruction_o  output  32  fetched instruction.
- valid_o  output  1  PC_o/instruction_o hold a real instruction.

Behaviour:
- Reset (async, any state, mid-request included): state=IDLE, fetch_pc=RESET_PC, PC_o=0, instruction_o=0, valid_o=0, skid empty, imem_req_o=0. Any in-flight ack after reset is ignored.
- States:
  - IDLE: one cycle after reset release -> REQ.
  - REQ: imem_req_o=1, imem_addr_o=fetch_pc.
  - HOLD: imem_req_o=0, skid full, waiting for stall release.
  - DROP: imem_req_o=1, imem_addr_o=in-flight address; awaiting ack to discard.
- Output register accepts when (stall_i==0 || valid_o==0).
- REQ, ack=1, no redirect:
  - Accept: PC_o<=fetch_pc, instruction_o<=imem_rdata_i, valid_o<=1, fetch_pc+=PC_STEP, stay REQ.
  - Not accepting: capture into skid, fetch_pc+=PC_STEP, -> HOLD.
- REQ, ack=0: hold address; if accepting, valid_o<=0.
- HOLD: when stall_i drops, skid -> output (valid_o=1), skid empty, -> REQ.
- Latency: ack at cycle N -> valid_o/instruction_o visible at cycle N+1.
- With zero-wait memory (ack same cycle as req), throughput is one instruction per cycle.
- Redirect (highest priority, overrides stall, any non-reset state):
  - valid_o<=0, instruction_o<=0, PC_o<=0; skid emptied.
  - fetch_pc<={redirect_pc_i[31:2],2'b00}.
  - REQ with ack=1 same cycle: response discarded -> REQ (new address next cycle).
  - REQ with ack=0: -> DROP (old address stays on bus).
  - HOLD/IDLE: -> REQ.
  - DROP: target updated, stay DROP.
- DROP, ack=1, no redirect: data discarded -> REQ at fetch_pc.
- While valid_o=0, no stale data is ever presented.
- Arithmetic: fetch_pc is 32-bit, wraps modulo 2^32 (32'hFFFFFFFC+4 -> 0).
- Handshake rule: the block never drops imem_req_o or changes imem_addr_o before ack, including across redirect and stall.
- Outputs PC_o, instruction_o, valid_o are registered.
- imem_req_o and imem_addr_o are decoded from state and registers only, with no combinational path from inputs.

Test Plan:
- Reset release, memory ack tied to req -> imem_addr_o 0,4,8,C on consecutive cycles; valid_o rises one cycle after first ack; PC_o follows 0,4,8.
- Stream, stall_i=1 for 3 cycles while ack for PC 0x10 arrives -> output holds PC 0x0C, state HOLD, imem_req_o=0; stall drop -> PC_o=0x10 next cycle, request for 0x14 follows.
- Memory 3-cycle latency, redirect_i with 0x200 one cycle after req for 0x08 -> imem_addr_o stays 0x08 until ack, data discarded, next request addr 0x200, valid_o=0 until 0x200 returns.
- Redirect to 0x103 in the same cycle as ack for 0x40 -> 0x40 never appears on outputs; next imem_addr_o=0x100.
- Redirect while stalled with skid full -> valid_o=0 next cycle, skid contents never emitted, fetch restarts at target.
- Assert rst mid-request, then release -> all outputs 0 immediately; late ack ignored; first request at RESET_PC after one IDLE cycle.
